mult_hilo_seq: RTL and testbench

//  Sequential shift-add multiplier with MIPS HI/LO result registers for the processor execute stage.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mult_pp_and.sv | 13 +
 rtl/mult_hilo_seq.sv | 142 ++++++++++++++
 tb/tb_mult_hilo_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types and constants.
// Used by the HI/LO multiplier and its helpers.
package mips_pkg;

  localparam int MIPS_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_pp_and.sv
// Partial product former for the shift-add multiplier.
// Gates the multiplicand with the current multiplier bit.
module mult_pp_and #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic             sel,
  output logic [WIDTH-1:0] pp
);

  assign pp = mcand & {WIDTH{sel}};

endmodule

// File: rtl/mult_hilo_seq.sv
// Sequential shift-add multiplier with MIPS HI/LO registers.
// Signed mult support is built only with MULT_SIGNED_EN defined.
module mult_hilo_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MIPS_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef MULT_SIGNED_EN
  input  logic             op_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;

  mult_pp_and #(
    .WIDTH(WIDTH)
  ) u_pp (
    .mcand(mcand),
    .sel  (mplier[0]),
    .pp   (pp)
  );

  // carry out of the add is kept as the shifted-in MSB
  assign sum = {1'b0, acc} + {1'b0, pp};

`ifdef MULT_SIGNED_EN
  logic             neg;
  logic             neg_in;
  logic [PW-1:0]    prod_neg;

  // magnitudes go through the unsigned core; the sign is fixed up at the end
  always_comb begin
    a_in   = a;
    b_in   = b;
    neg_in = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    if (op_signed && a[WIDTH-1])
      a_in = ~a + WIDTH'(1);
    if (op_signed && b[WIDTH-1])
      b_in = ~b + WIDTH'(1);
  end

  assign prod_neg = ~{acc, mplier} + PW'(1);
`else
  assign a_in = a;
  assign b_in = b;
`endif

  // control FSM, shift-add datapath and HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
`ifdef MULT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef MULT_SIGNED_EN
            neg    <= neg_in;
`endif
          end else begin
            if (hi_we)
              hi <= wdata;
            if (lo_we)
              lo <= wdata;
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
`ifdef MULT_SIGNED_EN
            state <= FIXUP;
`else
            state <= DONE;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        FIXUP: begin
          if (neg)
            {acc, mplier} <= prod_neg;
          state <= DONE;
        end
`endif
        DONE: begin
          hi    <= acc;
          lo    <= mplier;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Directed scoreboard bench for mult_hilo_seq.
// Covers latency, HI/LO writes, ignored starts and mid-op reset.
module tb_mult_hilo_seq;

  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULT_SIGNED_EN
  logic         op_signed;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int k_cyc = 0;
  logic [2*W-1:0] q[$];

  mult_hilo_seq #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
`ifdef MULT_SIGNED_EN
    .op_signed(op_signed),
`endif
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input bit sg);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (sg) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic start_op(input logic [W-1:0] x,
                          input logic [W-1:0] y,
                          input bit sg);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
`ifdef MULT_SIGNED_EN
    op_signed = sg;
`endif
    q.push_back(model(x, y, sg));
    @(posedge clk);
    #1;
    k_cyc = cyc;
    start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(cyc - k_cyc), 64'(LAT));
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      exp = q.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, exp);
    end
    chk({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int dn;
    logic [W-1:0] hold_hi;
    reset_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
`ifdef MULT_SIGNED_EN
    op_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    start_op(32'd7, 32'd6, 1'b0);
    wait_done("t1_7x6");

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("t2_max");
    chk("t2_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    chk("t2_lo", {32'b0, lo}, 64'h1);

    start_op(32'h8000_0000, 32'd3, 1'b0);
    wait_done("t2b_msb");

`ifdef MULT_SIGNED_EN
    start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done("t3_signed");
    chk("t3_hi_s", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("t3_lo_s", {32'b0, lo}, 64'hFFFF_FFF1);
    start_op(32'hFFFF_FFFD, 32'd5, 1'b0);
    wait_done("t3_unsigned");
    chk("t3_hi_u", {32'b0, hi}, 64'h4);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("t3_minneg");
    start_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    wait_done("t3_minpos");
`endif

    hold_hi = hi;
    start_op(32'd100, 32'd200, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a = 32'd5;
    b = 32'd5;
    hi_we = 1'b1;
    wdata = 32'hABCD;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    chk("t4_hi_hold_run", {32'b0, hi}, {32'b0, hold_hi});
    wait_done("t4_ignored");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_queue", {63'b0, busy}, 64'd0);

    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("t4_mthi", {hi, lo}, {32'h1234, 32'd20000});

    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("t4_both_we", {hi, lo}, {32'hCAFE, 32'hCAFE});

    start_op(32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", {63'b0, busy}, 64'd0);
    chk("t5_hilo", {hi, lo}, 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("t5_no_done", 64'(dn), 64'd0);
    start_op(32'd2, 32'd3, 1'b0);
    wait_done("t5_2x3");

    @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD;
`ifdef MULT_SIGNED_EN
    op_signed = 1'b0;
`endif
    q.push_back(model(32'd1, 32'd1, 1'b0));
    @(posedge clk);
    #1;
    k_cyc = cyc;
    start = 1'b0;
    lo_we = 1'b0;
    chk("t6_lo_dropped", {32'b0, lo}, 64'd6);
    wait_done("t6_start_wins");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
